// File: rtl/mult_rr_arbiter.sv
// mult_rr_arbiter: round-robin front end sharing one GO/READY multiplier.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN (limit TMO_CYCLES).
module mult_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int OP_W       = 3,
  parameter int TMO_CYCLES = 64
) (
  input  logic                  SYS_CLOCK,
  input  logic                  SYS_ARESET_N,
  input  logic [N_REQ-1:0]      REQ,
  input  logic [N_REQ*OP_W-1:0] A_IN,
  input  logic [N_REQ*OP_W-1:0] B_IN,
  input  logic                  MULT_READY,
  input  logic [2*OP_W-1:0]     MULT_Y,
  output logic                  MULT_GO,
  output logic [OP_W-1:0]       MULT_A,
  output logic [OP_W-1:0]       MULT_B,
  output logic [N_REQ-1:0]      GNT,
  output logic [N_REQ-1:0]      DONE,
  output logic [2*OP_W-1:0]     RESULT,
  output logic                  ERR
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic [OP_W-1:0]     a_q, a_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic                go_q, go_d;
  logic [2*OP_W-1:0]   res_q, res_d;
  logic                err_q, err_d;
  logic                pick_vld;
  logic [PW-1:0]       pick_idx;
  logic                tmo_hit;

  // Round-robin scan: first set request at or after ptr.
  always_comb begin
    int j;
    logic [PW-1:0] jj;
    pick_vld = 1'b0;
    pick_idx = '0;
    j = 0;
    jj = '0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      jj = PW'(j);
      if (!pick_vld && REQ[jj]) begin
        pick_vld = 1'b1;
        pick_idx = jj;
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          in_wait;

  assign in_wait = (state_q == S_WAIT_BUSY) ||
                   (state_q == S_WAIT_DONE);
  assign tmo_hit = in_wait &&
                   (tmo_q == TW'(TMO_CYCLES - 1));

  // Wait-state cycle counter; restarts on every state change.
  always_ff @(posedge SYS_CLOCK or negedge SYS_ARESET_N) begin
    if (!SYS_ARESET_N) begin
      tmo_q <= '0;
    end else if (!in_wait || state_d != state_q) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  localparam int UNUSED_TMO = TMO_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    a_d     = a_q;
    b_d     = b_q;
    go_d    = 1'b0;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (MULT_READY && pick_vld) begin
          state_d = S_LAUNCH;
          gidx_d  = pick_idx;
          gnt_d   = N_REQ'(1) << pick_idx;
          a_d     = OP_W'(A_IN >> (pick_idx * OP_W));
          b_d     = OP_W'(B_IN >> (pick_idx * OP_W));
          go_d    = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!MULT_READY) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_hit) begin
          state_d = S_RESP;
          done_d  = N_REQ'(1) << gidx_q;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (MULT_READY) begin
          state_d = S_RESP;
          done_d  = N_REQ'(1) << gidx_q;
          res_d   = MULT_Y;
          err_d   = 1'b0;
        end else if (tmo_hit) begin
          state_d = S_RESP;
          done_d  = N_REQ'(1) << gidx_q;
          res_d   = '0;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        done_d  = '0;
        err_d   = 1'b0;
        gnt_d   = '0;
        ptr_d   = (gidx_q == PW'(N_REQ - 1)) ?
                  '0 : gidx_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge SYS_CLOCK or negedge SYS_ARESET_N) begin
    if (!SYS_ARESET_N) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      go_q    <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      a_q     <= a_d;
      b_q     <= b_d;
      go_q    <= go_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign MULT_GO = go_q;
  assign MULT_A  = a_q;
  assign MULT_B  = b_q;
  assign GNT     = gnt_q;
  assign DONE    = done_q;
  assign RESULT  = res_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// tb_mult_rr_arbiter: directed bench with a transaction-level model
// and a behavioural GO/READY multiplier stub.
module tb_mult_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 3;
  localparam int AW = N * W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   REQ;
  logic [AW-1:0]  A_IN;
  logic [AW-1:0]  B_IN;
  logic           MULT_READY;
  logic [2*W-1:0] MULT_Y;
  logic           MULT_GO;
  logic [W-1:0]   MULT_A;
  logic [W-1:0]   MULT_B;
  logic [N-1:0]   GNT;
  logic [N-1:0]   DONE;
  logic [2*W-1:0] RESULT;
  logic           ERR;

  int nchk = 0;
  int nerr = 0;
  int lat  = 3;

  mult_rr_arbiter #(
    .N_REQ(N),
    .OP_W(W),
    .TMO_CYCLES(64)
  ) dut (
    .SYS_CLOCK(clk),
    .SYS_ARESET_N(rst_n),
    .REQ(REQ),
    .A_IN(A_IN),
    .B_IN(B_IN),
    .MULT_READY(MULT_READY),
    .MULT_Y(MULT_Y),
    .MULT_GO(MULT_GO),
    .MULT_A(MULT_A),
    .MULT_B(MULT_B),
    .GNT(GNT),
    .DONE(DONE),
    .RESULT(RESULT),
    .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Multiplier stub: busy for lat cycles after GO, junk on Y while busy.
  int             m_cnt;
  logic [2*W-1:0] m_py;
  always @(negedge clk) begin
    if (!rst_n) begin
      MULT_READY <= 1'b1;
      MULT_Y     <= '0;
      m_cnt      <= 0;
      m_py       <= '0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        MULT_READY <= 1'b1;
        MULT_Y     <= m_py;
      end
    end else if (MULT_GO) begin
      MULT_READY <= 1'b0;
      m_py   <= {{W{1'b0}}, MULT_A} * {{W{1'b0}}, MULT_B};
      MULT_Y <= ~({{W{1'b0}}, MULT_A} * {{W{1'b0}}, MULT_B});
      m_cnt  <= lat;
    end
  end

  // Reference model: who is served, with which operands, and when.
  int             mptr = 0;
  int             win = -1;
  int             k = 0;
  bit             low_seen = 1'b0;
  bit             in_resp = 1'b0;
  bit             go_e;
  bit             done_e;
  logic [W-1:0]   ea = '0;
  logic [W-1:0]   eb = '0;
  logic [2*W-1:0] exp_y = '0;
  logic [2*W-1:0] last_res = '0;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] s;
    for (int i = 0; i < N; i++) begin
      s = r >> ((p + i) % N);
      if (s[0]) return (p + i) % N;
    end
    return -1;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mptr = 0;
      win = -1;
      in_resp = 1'b0;
      low_seen = 1'b0;
      last_res = '0;
    end else begin
      go_e = 1'b0;
      done_e = 1'b0;
      if (win < 0) begin
        if (REQ != '0 && MULT_READY) begin
          win = rr_pick(REQ, mptr);
          ea = W'(A_IN >> (win * W));
          eb = W'(B_IN >> (win * W));
          exp_y = {{W{1'b0}}, ea} * {{W{1'b0}}, eb};
          go_e = 1'b1;
          k = 0;
          low_seen = 1'b0;
          in_resp = 1'b0;
        end
      end else if (in_resp) begin
        mptr = (win + 1) % N;
        win = -1;
        in_resp = 1'b0;
      end else begin
        k++;
        if (k >= 2) begin
          if (!low_seen) begin
            low_seen = !MULT_READY;
          end else if (MULT_READY) begin
            done_e = 1'b1;
            in_resp = 1'b1;
            last_res = exp_y;
          end
        end
      end
      chk("m_gnt", GNT,
          (win < 0) ? 32'd0 : (32'd1 << win));
      chk("m_go", MULT_GO, go_e);
      chk("m_done", DONE,
          done_e ? (32'd1 << win) : 32'd0);
      chk("m_result", RESULT, last_res);
      chk("m_err", ERR, 0);
      if (win >= 0) begin
        chk("m_mult_a", MULT_A, ea);
        chk("m_mult_b", MULT_B, eb);
      end
    end
  end

  task automatic set_op(input int i, input int a, input int b);
    logic [AW-1:0] m;
    m = AW'((1 << W) - 1) << (i * W);
    A_IN = (A_IN & ~m) | ((AW'(a) << (i * W)) & m);
    B_IN = (B_IN & ~m) | ((AW'(b) << (i * W)) & m);
  endtask

  task automatic wait_gnt(input string nm);
    int n;
    n = 0;
    while (GNT == '0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    nchk++;
    if (GNT == '0) begin
      nerr++;
      $display("FAIL %s: no grant within %0d cycles", nm, n);
    end
  endtask

  task automatic serve(input string nm,
                       input logic [N-1:0] ed,
                       input logic [2*W-1:0] er);
    int n;
    logic [N-1:0] d;
    n = 0;
    d = '0;
    while (n < 80) begin
      @(posedge clk);
      #1;
      n++;
      if (DONE != '0) begin
        d = DONE;
        break;
      end
    end
    chk({nm, "_done"}, d, ed);
    if (d != '0) begin
      chk({nm, "_result"}, RESULT, er);
      @(negedge clk);
      REQ = REQ & ~d;
      @(posedge clk);
      #1;
      chk({nm, "_gnt_clr"}, GNT, 0);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_gnt"}, GNT, 0);
    chk({nm, "_done"}, DONE, 0);
    chk({nm, "_go"}, MULT_GO, 0);
    chk({nm, "_a"}, MULT_A, 0);
    chk({nm, "_b"}, MULT_B, 0);
    chk({nm, "_result"}, RESULT, 0);
    chk({nm, "_err"}, ERR, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    REQ = '0;
    A_IN = '0;
    B_IN = '0;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    #1 rst_n = 1'b1;

    @(negedge clk);
    set_op(0, 3, 5);
    REQ = 4'b0001;
    serve("single", 4'b0001, 6'd15);

    pulse_rst();
    @(negedge clk);
    set_op(0, 7, 7);
    set_op(1, 0, 5);
    set_op(2, 6, 3);
    set_op(3, 4, 5);
    REQ = 4'b1111;
    serve("rr_a0", 4'b0001, 6'd49);
    serve("rr_a1", 4'b0010, 6'd0);
    serve("rr_a2", 4'b0100, 6'd18);
    serve("rr_a3", 4'b1000, 6'd20);

    @(negedge clk);
    set_op(0, 2, 3);
    set_op(1, 5, 5);
    set_op(2, 7, 1);
    set_op(3, 3, 6);
    REQ = 4'b1111;
    serve("rr_b0", 4'b0001, 6'd6);
    serve("rr_b1", 4'b0010, 6'd25);
    serve("rr_b2", 4'b0100, 6'd7);
    serve("rr_b3", 4'b1000, 6'd18);

    @(negedge clk);
    set_op(2, 5, 6);
    REQ = 4'b0100;
    wait_gnt("drop_gnt");
    @(negedge clk);
    REQ[2] = 1'b0;
    set_op(2, 1, 1);
    set_op(0, 2, 2);
    set_op(3, 7, 3);
    REQ[0] = 1'b1;
    REQ[3] = 1'b1;
    serve("drop2", 4'b0100, 6'd30);
    serve("next3", 4'b1000, 6'd21);
    serve("then0", 4'b0001, 6'd4);

    lat = 8;
    @(negedge clk);
    set_op(1, 3, 3);
    REQ = 4'b0010;
    wait_gnt("rst_gnt");
    repeat (4) @(posedge clk);
    @(negedge clk);
    set_op(3, 6, 7);
    REQ[3] = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    REQ[1] = 1'b0;
    lat = 3;
    @(negedge clk);
    #2 rst_n = 1'b1;
    serve("after_rst", 4'b1000, 6'd42);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
